// File: rtl/fifo_read_arbiter_if.sv
// Read-side FIFO arbiter bus: FIFO read port, consumer requests/grants and output stage.
interface fifo_read_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ID_WIDTH   = 2
);
  logic                  empty;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_en;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    gnt;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic [ID_WIDTH-1:0]   m_id;
  logic                  m_last;
  logic [NUM_REQ-1:0]    m_ready;
  logic                  busy;

  // Arbiter side.
  modport master (
    input  empty, r_data, req, m_ready,
    output r_en, gnt, m_valid, m_data, m_id, m_last, busy
  );

  // FIFO / consumer side.
  modport slave (
    output empty, r_data, req, m_ready,
    input  r_en, gnt, m_valid, m_data, m_id, m_last, busy
  );
endinterface

// File: rtl/fifo_read_arbiter.sv
// Round-robin read scheduler for the async FIFO read port, with bounded bursts per grant
// and a one-entry registered output stage (valid/ready).
module fifo_read_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4,
  parameter int unsigned ID_WIDTH   = 2
) (
  input  logic                r_clk,
  input  logic                r_rst_n,
  fifo_read_arbiter_if.master bus_io
);

  localparam int unsigned CntWidth = $clog2(MAX_BURST + 1);
  localparam logic [CntWidth-1:0] BurstMax  = CntWidth'(MAX_BURST);
  localparam logic [CntWidth-1:0] BurstLast = CntWidth'(MAX_BURST - 1);

  typedef enum logic [1:0] {StIdle, StXfer, StDrain} state_e;

  state_e                state_q, state_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [ID_WIDTH-1:0]   g_q, g_d;
  logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [ID_WIDTH-1:0]   m_id_q, m_id_d;
  logic                  m_last_q, m_last_d;

  logic [ID_WIDTH-1:0]   pick;
  logic [ID_WIDTH-1:0]   scan_idx;
  logic                  found;
  logic                  accept;
  logic                  pop;

  // Round-robin pick: first requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick     = ptr_q;
    scan_idx = ptr_q;
    found    = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_idx = ID_WIDTH'((32'(ptr_q) + i) % NUM_REQ);
      if (!found && bus_io.req[scan_idx]) begin
        pick  = scan_idx;
        found = 1'b1;
      end
    end
  end

  // Pop whenever granted data is available, burst budget remains and the output slot frees up.
  always_comb begin
    accept = m_valid_q & bus_io.m_ready[m_id_q];
    pop    = (state_q == StXfer) & ~bus_io.empty & bus_io.req[g_q] & (cnt_q < BurstMax) &
             (~m_valid_q | bus_io.m_ready[m_id_q]);
  end

  // Next-state logic for FSM, grant, burst counter and output register.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    g_d       = g_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_id_d    = m_id_q;
    m_last_d  = m_last_q;

    // Pop and accept in the same cycle reloads the register without a bubble.
    if (pop) begin
      m_valid_d = 1'b1;
      m_data_d  = bus_io.r_data;
      m_id_d    = g_q;
      m_last_d  = (cnt_q == BurstLast);
      cnt_d     = cnt_q + 1'b1;
    end else if (accept) begin
      m_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (found) begin
          gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
          g_d     = pick;
          cnt_d   = '0;
          ptr_d   = ID_WIDTH'((32'(pick) + 1) % NUM_REQ);
          state_d = StXfer;
        end
      end
      StXfer: begin
        if (pop && (cnt_q == BurstLast)) begin
          state_d = StDrain;
        end else if (!bus_io.req[g_q]) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Hold the grant until the last word of this grant has left the output register.
        if (!m_valid_q || accept) begin
          gnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers, asynchronous active-low reset.
  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      g_q       <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_id_q    <= '0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      g_q       <= g_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_id_q    <= m_id_d;
      m_last_q  <= m_last_d;
    end
  end

  // Output drive.
  always_comb begin
    bus_io.r_en    = pop;
    bus_io.gnt     = gnt_q;
    bus_io.m_valid = m_valid_q;
    bus_io.m_data  = m_data_q;
    bus_io.m_id    = m_id_q;
    bus_io.m_last  = m_last_q;
    bus_io.busy    = (state_q != StIdle) | m_valid_q;
  end

endmodule
